// File: rtl/system_clk_en_gen_if.sv
// Configuration port of system_clk_en_gen: valid/ready handshake carrying
// channel select, divide ratio and phase offset.
interface system_clk_en_gen_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_phase;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      output cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      input  cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/system_clk_en_gen.sv
// NUM_CH runtime-programmable clock-enable pulse trains derived from refclk,
// with a PLL-style align / lock-settle sequence restarted by every reconfiguration.
module system_clk_en_gen #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 256,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 refclk,
   input  logic                 rst_n,
   input  logic                 soft_rst,
   system_clk_en_gen_if.slave   cfg,
   output logic [NUM_CH-1:0]    clk_en,
   output logic                 locked,
   output logic                 sync_pulse
);

   localparam int LCW = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ALIGN   = 2'd1,
      S_LOCKING = 2'd2,
      S_LOCKED  = 2'd3
   } state_e;

   // A divide ratio of 0 behaves like 1: the channel fires every cycle.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      logic [DIV_W-1:0] r;
      if (d == {DIV_W{1'b0}}) begin
         r = DIV_W'(1);
      end else begin
         r = d;
      end
      return r;
   endfunction

   function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] d,
                                                    input logic [DIV_W-1:0] p);
      logic [DIV_W-1:0] de;
      logic [DIV_W-1:0] r;
      de = eff_div(d);
      if (p >= de) begin
         r = de - DIV_W'(1);
      end else begin
         r = p;
      end
      return r;
   endfunction

   state_e            state_q,    state_d;
   logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [DIV_W-1:0]  div_q   [NUM_CH];
   logic [DIV_W-1:0]  div_d   [NUM_CH];
   logic [DIV_W-1:0]  phase_q [NUM_CH];
   logic [DIV_W-1:0]  phase_d [NUM_CH];
   logic [DIV_W-1:0]  cnt_q   [NUM_CH];
   logic [DIV_W-1:0]  cnt_d   [NUM_CH];
   logic [DIV_W-1:0]  cnt_inc_s [NUM_CH];
   logic [NUM_CH-1:0] clk_en_q,   clk_en_d;
   logic              locked_q,   locked_d;
   logic              sync_q,     sync_d;
   logic              cfg_ready_s;
   logic              wr_hit_s;
   logic              wr_en_s;

   assign cfg_ready_s   = (state_q != S_ALIGN) && !soft_rst && rst_n;
   assign cfg.cfg_ready = cfg_ready_s;
   assign clk_en        = clk_en_q;
   assign locked        = locked_q;
   assign sync_pulse    = sync_q;

   // Free-running wrap of each channel counter at its effective divide.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_q[i] >= eff_div(div_q[i]) - DIV_W'(1)) begin
            cnt_inc_s[i] = {DIV_W{1'b0}};
         end else begin
            cnt_inc_s[i] = cnt_q[i] + DIV_W'(1);
         end
      end
   end

   // Next-state logic: soft restart beats a transfer, a transfer beats sequencing.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      div_d      = div_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      wr_hit_s   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit_s = wr_hit_s | (cfg.cfg_ch == CH_W'(i));
      end
      wr_en_s = cfg.cfg_valid & cfg_ready_s & wr_hit_s;

      if (soft_rst) begin
         state_d    = S_IDLE;
         lock_cnt_d = {LCW{1'b0}};
      end else if (wr_en_s) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
               div_d[i]   = cfg.cfg_div;
               phase_d[i] = clamp_phase(cfg.cfg_div, cfg.cfg_phase);
            end else begin
               div_d[i]   = div_q[i];
               phase_d[i] = phase_q[i];
            end
         end
         state_d = S_ALIGN;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ALIGN;
            end
            S_ALIGN: begin
               cnt_d      = phase_q;
               lock_cnt_d = {LCW{1'b0}};
               state_d    = S_LOCKING;
            end
            S_LOCKING: begin
               cnt_d = cnt_inc_s;
               if (lock_cnt_q != LCW'(LOCK_CYCLES)) begin
                  lock_cnt_d = lock_cnt_q + LCW'(1);
               end else begin
                  lock_cnt_d = lock_cnt_q;
               end
               if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                  state_d = S_LOCKED;
               end else begin
                  state_d = S_LOCKING;
               end
            end
            S_LOCKED: begin
               cnt_d = cnt_inc_s;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from next-state values so they can be registered.
   always_comb begin
      locked_d = (state_d == S_LOCKED);
      sync_d   = locked_d;
      clk_en_d = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         clk_en_d[i] = locked_d && (cnt_d[i] == eff_div(div_d[i]) - DIV_W'(1));
         sync_d      = sync_d && (cnt_d[i] == {DIV_W{1'b0}});
      end
   end

   // State, configuration and output registers.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         lock_cnt_q <= {LCW{1'b0}};
         clk_en_q   <= {NUM_CH{1'b0}};
         locked_q   <= 1'b0;
         sync_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= DIV_W'(DEFAULT_DIV);
            phase_q[i] <= {DIV_W{1'b0}};
            cnt_q[i]   <= {DIV_W{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         clk_en_q   <= clk_en_d;
         locked_q   <= locked_d;
         sync_q     <= sync_d;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= div_d[i];
            phase_q[i] <= phase_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_system_clk_en_gen.sv
// Directed bench for system_clk_en_gen: a cycle model pushes expected outputs
// into a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_system_clk_en_gen;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 2;
   localparam int LOCK_CYCLES = 16;
   localparam int CH_W        = 3;

   localparam int M_IDLE    = 0;
   localparam int M_ALIGN   = 1;
   localparam int M_LOCKING = 2;
   localparam int M_LOCKED  = 3;

   typedef struct packed {
      logic [NUM_CH-1:0] ce;
      logic              lk;
      logic              sp;
   } exp_t;

   logic              refclk = 1'b0;
   logic              rst_n;
   logic              soft_rst;
   logic [NUM_CH-1:0] clk_en;
   logic              locked;
   logic              sync_pulse;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   int m_state;
   int m_t;
   int m_div [NUM_CH];
   int m_ph  [NUM_CH];

   system_clk_en_gen_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg ();

   system_clk_en_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV),
      .LOCK_CYCLES(LOCK_CYCLES), .CH_W(CH_W)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .soft_rst(soft_rst), .cfg(cfg),
      .clk_en(clk_en), .locked(locked), .sync_pulse(sync_pulse)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int deff(input int d);
      return (d < 1) ? 1 : d;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_t     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DEFAULT_DIV;
         m_ph[i]  = 0;
      end
   endtask

   // Channel i's counter is (phase + cycles since LOCKING entry) mod divide.
   function automatic exp_t model_out();
      exp_t e;
      logic all0;
      int   c;
      e.lk = (m_state == M_LOCKED);
      e.ce = '0;
      all0 = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         c       = (m_ph[i] + m_t) % deff(m_div[i]);
         e.ce[i] = e.lk && (c == deff(m_div[i]) - 1);
         all0    = all0 && (c == 0);
      end
      e.sp = e.lk && all0;
      return e;
   endfunction

   task automatic step();
      logic rdy;
      int   d;
      int   ch;
      exp_t e;
      #1;
      rdy = rst_n && !soft_rst && (m_state != M_ALIGN);
      chk("cfg_ready", cfg.cfg_ready, rdy);
      ch = int'(cfg.cfg_ch);
      if (!rst_n) begin
         model_reset();
      end else if (soft_rst) begin
         m_state = M_IDLE;
      end else if (cfg.cfg_valid && rdy && ch < NUM_CH) begin
         d         = deff(int'(cfg.cfg_div));
         m_div[ch] = int'(cfg.cfg_div);
         m_ph[ch]  = (int'(cfg.cfg_phase) >= d) ? d - 1 : int'(cfg.cfg_phase);
         m_state   = M_ALIGN;
      end else begin
         case (m_state)
            M_IDLE:    m_state = M_ALIGN;
            M_ALIGN:   begin m_state = M_LOCKING; m_t = 0; end
            M_LOCKING: begin m_t++; if (m_t == LOCK_CYCLES) m_state = M_LOCKED; end
            default:   m_t++;
         endcase
      end
      sb.push_back(model_out());
      @(posedge refclk);
      #1;
      e = sb.pop_front();
      chk("clk_en", clk_en, e.ce);
      chk("locked", locked, e.lk);
      chk("sync_pulse", sync_pulse, e.sp);
   endtask

   task automatic cfg_write(input int ch, input int dv, input int ph);
      cfg.cfg_ch    = CH_W'(ch);
      cfg.cfg_div   = DIV_W'(dv);
      cfg.cfg_phase = DIV_W'(ph);
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
   endtask

   // Edges counted from n0 until locked rises; relock must take LOCK_CYCLES+2 edges.
   task automatic lock_wait(input string tag, input int n0);
      int n;
      n = n0;
      while (locked !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk(tag, n, LOCK_CYCLES + 2);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_clk_en"}, clk_en, '0);
      chk({tag, "_locked"}, locked, 1'b0);
      chk({tag, "_sync"}, sync_pulse, 1'b0);
      chk({tag, "_ready"}, cfg.cfg_ready, 1'b0);
      model_reset();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      soft_rst      = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_ch    = '0;
      cfg.cfg_div   = '0;
      cfg.cfg_phase = '0;
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;

      lock_wait("t1_lock_latency", 0);
      repeat (8) step();

      cfg_write(1, 5, 2);
      lock_wait("t2_relock", 1);
      repeat (24) step();

      cfg_write(2, 4, 9);
      lock_wait("t3_relock", 1);
      repeat (12) step();

      cfg_write(3, 0, 0);
      lock_wait("t4_relock", 1);
      repeat (6) step();

      // Soft restart with a colliding request that must not transfer.
      soft_rst      = 1'b1;
      cfg.cfg_ch    = CH_W'(0);
      cfg.cfg_div   = DIV_W'(7);
      cfg.cfg_phase = DIV_W'(1);
      cfg.cfg_valid = 1'b1;
      step();
      cfg.cfg_valid = 1'b0;
      step();
      step();
      soft_rst = 1'b0;
      lock_wait("t5_relock", 0);
      repeat (10) step();

      cfg_write(3, 3, 1);
      lock_wait("t6_relock", 1);
      cfg_write(7, 9, 0);
      chk("t6_ignored_locked", locked, 1'b1);
      repeat (6) step();
      cfg_write(0, 3, 2);
      repeat (4) step();
      cfg_write(1, 6, 5);
      lock_wait("t6_restart_relock", 1);
      cfg_write(2, 2, 1);
      repeat (5) step();
      async_reset("t6_rst_locking");
      lock_wait("t6_post_rst_lock", 0);
      repeat (6) step();
      async_reset("t6_rst_locked");
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
